multdiv_seq: RTL

- Iterative signed multiply/divide unit. It is the responder to the execute-stage decode that raises is_mult/is_div pulses.
- Latches operands and the destination tag on a start pulse, then iterates over many cycles.
- Drives a pipeline stall while computing, then presents the result, exception flag and tag for writeback for exactly one cycle.

---
 rtl/multdiv_seq_if.sv | 27 ++
 rtl/multdiv_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_seq_if.sv
// Handshake/data bundle between the execute-stage decode and the iterative
// multiply/divide unit.
interface multdiv_seq_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [TAG_W-1:0] in_rd;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic [TAG_W-1:0] out_rd;
  logic             stall;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, in_rd,
    input  data_result, data_exception, data_resultRDY, out_rd, stall
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, in_rd,
    output data_result, data_exception, data_resultRDY, out_rd, stall
  );
endinterface

// File: rtl/multdiv_seq.sv
// Iterative signed multiply (Booth) / divide (restoring) unit with pipeline stall.
// Define MULTDIV_RADIX4_EN to switch the multiplier to radix-4 Booth recoding.
module multdiv_seq #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input logic          clock,
  input logic          reset,
  multdiv_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

`ifdef MULTDIV_RADIX4_EN
  localparam logic [5:0] MUL_ITERS = 6'(WIDTH / 2);
`else
  localparam logic [5:0] MUL_ITERS = 6'(WIDTH);
`endif
  localparam logic [5:0] DIV_ITERS = 6'(WIDTH);

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             neg_q, neg_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic [TAG_W-1:0] rd_q, rd_d;

  logic [WIDTH-1:0] abs_a_s, abs_b_s;
  logic [WIDTH-1:0] mul_acc_s, mul_lo_s;
  logic             mul_qm1_s, mul_ovf_s;
  logic [WIDTH:0]   mul_hi_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH-1:0] div_diff_s, div_acc_s, div_lo_s;
  logic             div_ge_s;
  logic             start_s;

  assign abs_a_s = bus.data_operandA[WIDTH-1] ? ({WIDTH{1'b0}} - bus.data_operandA) : bus.data_operandA;
  assign abs_b_s = bus.data_operandB[WIDTH-1] ? ({WIDTH{1'b0}} - bus.data_operandB) : bus.data_operandB;
  assign start_s = ((state_q == IDLE) || (state_q == DONE)) && (bus.ctrl_MULT || bus.ctrl_DIV);

  // Upper half of the 2*WIDTH product plus the sign bit of the low word must be a pure sign extension.
  assign mul_hi_s  = {acc_q, lo_q[WIDTH-1]};
  assign mul_ovf_s = !((mul_hi_s == {(WIDTH+1){1'b0}}) || (mul_hi_s == {(WIDTH+1){1'b1}}));

`ifdef MULTDIV_RADIX4_EN
  logic [WIDTH+1:0] m_ext_s, addend_s, sum_s;

  // One radix-4 Booth step: add digit*multiplicand in {-2..2}, then arithmetic shift right by two.
  always_comb begin
    m_ext_s = {{2{mcand_q[WIDTH-1]}}, mcand_q};
    case ({lo_q[1:0], qm1_q})
      3'b001, 3'b010: addend_s = m_ext_s;
      3'b011:         addend_s = {m_ext_s[WIDTH:0], 1'b0};
      3'b100:         addend_s = {(WIDTH+2){1'b0}} - {m_ext_s[WIDTH:0], 1'b0};
      3'b101, 3'b110: addend_s = {(WIDTH+2){1'b0}} - m_ext_s;
      default:        addend_s = {(WIDTH+2){1'b0}};
    endcase
    sum_s     = {{2{acc_q[WIDTH-1]}}, acc_q} + addend_s;
    mul_acc_s = sum_s[WIDTH+1:2];
    mul_lo_s  = {sum_s[1:0], lo_q[WIDTH-1:2]};
    mul_qm1_s = lo_q[1];
  end
`else
  logic [WIDTH:0] m_ext_s, sum_s;

  // One radix-2 Booth step; the extra top bit keeps the add exact for the most negative multiplicand.
  always_comb begin
    m_ext_s = {mcand_q[WIDTH-1], mcand_q};
    case ({lo_q[0], qm1_q})
      2'b01:   sum_s = {acc_q[WIDTH-1], acc_q} + m_ext_s;
      2'b10:   sum_s = {acc_q[WIDTH-1], acc_q} - m_ext_s;
      default: sum_s = {acc_q[WIDTH-1], acc_q};
    endcase
    mul_acc_s = sum_s[WIDTH:1];
    mul_lo_s  = {sum_s[0], lo_q[WIDTH-1:1]};
    mul_qm1_s = lo_q[0];
  end
`endif

  // One restoring-division step on magnitudes; the remainder always fits WIDTH bits.
  always_comb begin
    div_shift_s = {acc_q, lo_q[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, mcand_q});
    div_diff_s  = div_shift_s[WIDTH-1:0] - mcand_q;
    if (div_ge_s) begin
      div_acc_s = div_diff_s;
      div_lo_s  = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      div_acc_s = div_shift_s[WIDTH-1:0];
      div_lo_s  = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    qm1_d   = qm1_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    tag_d   = tag_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_s) begin
          tag_d = bus.in_rd;
          cnt_d = 6'd0;
          acc_d = {WIDTH{1'b0}};
          qm1_d = 1'b0;
          if (bus.ctrl_MULT) begin
            state_d = MULT;
            lo_d    = bus.data_operandB;
            mcand_d = bus.data_operandA;
            neg_d   = 1'b0;
          end else begin
            state_d = DIV;
            lo_d    = abs_a_s;
            mcand_d = abs_b_s;
            neg_d   = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
          end
        end else begin
          state_d = IDLE;
        end
      end
      MULT: begin
        if (cnt_q == MUL_ITERS) begin
          state_d = DONE;
          res_d   = lo_q;
          exc_d   = mul_ovf_s;
          rd_d    = tag_q;
        end else begin
          acc_d = mul_acc_s;
          lo_d  = mul_lo_s;
          qm1_d = mul_qm1_s;
          cnt_d = cnt_q + 6'd1;
        end
      end
      DIV: begin
        if ((cnt_q == 6'd0) && (mcand_q == {WIDTH{1'b0}})) begin
          state_d = DONE;
          res_d   = {WIDTH{1'b0}};
          exc_d   = 1'b1;
          rd_d    = tag_q;
        end else if (cnt_q == DIV_ITERS) begin
          state_d = DONE;
          res_d   = neg_q ? ({WIDTH{1'b0}} - lo_q) : lo_q;
          // Only MIN / -1 yields a positive quotient with the top bit set.
          exc_d   = !neg_q && lo_q[WIDTH-1];
          rd_d    = tag_q;
        end else begin
          acc_d = div_acc_s;
          lo_d  = div_lo_s;
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      acc_q   <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      qm1_q   <= 1'b0;
      mcand_q <= {WIDTH{1'b0}};
      neg_q   <= 1'b0;
      tag_q   <= {TAG_W{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      exc_q   <= 1'b0;
      rd_q    <= {TAG_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      qm1_q   <= qm1_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.data_result    = res_q;
  assign bus.data_exception = exc_q;
  assign bus.out_rd         = rd_q;
  assign bus.data_resultRDY = (state_q == DONE);
  assign bus.stall          = (state_q == MULT) || (state_q == DIV);

endmodule
